// File: rtl/vga_box_bounce.sv
// rtl/vga_box_bounce.sv - bouncing-box pixel colour stage behind a VGA timing generator
//
// Purpose:
//   Draws a solid BOX_W x BOX_H rectangle in the active area. The rectangle
//   moves STEP pixels per axis once per frame and bounces off the active-area
//   edges. Its colour advances on every bounce. Sync outputs are re-registered
//   so that they stay aligned with the registered RGB.
//
// Optional build macro:
//   BOX_BORDER_EN - when defined, the outermost active row/column is drawn white
//                   (3'b111) over both box and background.
//
// Ports:
//   clk        in   pixel clock
//   reset      in   asynchronous active-high reset
//   hys, vys   in   horizontal / vertical sync (low during the pulse)
//   valid      in   active-video flag
//   pix_x      in   [9:0] active-area column (used only when valid=1)
//   pix_y      in   [9:0] active-area row (used only when valid=1)
//   move_en    in   1 = box advances on each frame tick
//   hys_o      out  hys delayed one clock
//   vys_o      out  vys delayed one clock
//   rgb_r/g/b  out  1-bit colour channels, registered
//   frame_cnt  out  [7:0] free-running frame counter

module vga_box_bounce #(
  parameter int         H_ACT  = 640,
  parameter int         V_ACT  = 480,
  parameter int         BOX_W  = 64,
  parameter int         BOX_H  = 48,
  parameter int         STEP   = 4,
  parameter logic [2:0] BG_RGB = 3'b000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hys,
  input  logic       vys,
  input  logic       valid,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic       move_en,
  output logic       hys_o,
  output logic       vys_o,
  output logic       rgb_r,
  output logic       rgb_g,
  output logic       rgb_b,
  output logic [7:0] frame_cnt
);

  localparam logic DIR_FWD = 1'b0;  // right on X, down on Y
  localparam logic DIR_REV = 1'b1;  // left on X, up on Y

  // 11-bit working width so box_pos + STEP + BOX_W cannot overflow.
  localparam logic [10:0] C_H_ACT = 11'(H_ACT);
  localparam logic [10:0] C_V_ACT = 11'(V_ACT);
  localparam logic [10:0] C_BOX_W = 11'(BOX_W);
  localparam logic [10:0] C_BOX_H = 11'(BOX_H);
  localparam logic [10:0] C_STEP  = 11'(STEP);
  localparam logic [9:0]  C_X_MAX = 10'(H_ACT - BOX_W);
  localparam logic [9:0]  C_Y_MAX = 10'(V_ACT - BOX_H);
`ifdef BOX_BORDER_EN
  localparam logic [9:0]  C_X_LAST = 10'(H_ACT - 1);
  localparam logic [9:0]  C_Y_LAST = 10'(V_ACT - 1);
`endif

  logic [9:0] r_box_x;
  logic [9:0] r_box_y;
  logic       r_dir_x;
  logic       r_dir_y;
  logic [2:0] r_colour;
  logic       r_vys_d;
  logic       r_hys_o;
  logic       r_vys_o;
  logic [2:0] r_rgb;
  logic [7:0] r_frame_cnt;

  logic       w_tick;
  logic [10:0] w_x_ext;
  logic [10:0] w_y_ext;
  logic [9:0] w_x_nxt;
  logic [9:0] w_y_nxt;
  logic       w_dir_x_nxt;
  logic       w_dir_y_nxt;
  logic       w_bounce_x;
  logic       w_bounce_y;
  logic [2:0] w_colour_nxt;
  logic       w_inside;
  logic [2:0] w_rgb_nxt;
`ifdef BOX_BORDER_EN
  logic       w_border;
`endif

  // Rising edge of vys marks the end of the vsync pulse: once per frame,
  // always inside vertical blanking.
  assign w_tick  = vys & ~r_vys_d;
  assign w_x_ext = {1'b0, r_box_x};
  assign w_y_ext = {1'b0, r_box_y};

  always_comb begin
    w_x_nxt     = r_box_x;
    w_dir_x_nxt = r_dir_x;
    w_bounce_x  = 1'b0;
    if (r_dir_x == DIR_FWD) begin
      if (w_x_ext + C_STEP + C_BOX_W > C_H_ACT) begin
        w_x_nxt     = C_X_MAX;
        w_dir_x_nxt = DIR_REV;
        w_bounce_x  = 1'b1;
      end else begin
        w_x_nxt = 10'(w_x_ext + C_STEP);
      end
    end else begin
      if (w_x_ext < C_STEP) begin
        w_x_nxt     = 10'd0;
        w_dir_x_nxt = DIR_FWD;
        w_bounce_x  = 1'b1;
      end else begin
        w_x_nxt = 10'(w_x_ext - C_STEP);
      end
    end
  end

  always_comb begin
    w_y_nxt     = r_box_y;
    w_dir_y_nxt = r_dir_y;
    w_bounce_y  = 1'b0;
    if (r_dir_y == DIR_FWD) begin
      if (w_y_ext + C_STEP + C_BOX_H > C_V_ACT) begin
        w_y_nxt     = C_Y_MAX;
        w_dir_y_nxt = DIR_REV;
        w_bounce_y  = 1'b1;
      end else begin
        w_y_nxt = 10'(w_y_ext + C_STEP);
      end
    end else begin
      if (w_y_ext < C_STEP) begin
        w_y_nxt     = 10'd0;
        w_dir_y_nxt = DIR_FWD;
        w_bounce_y  = 1'b1;
      end else begin
        w_y_nxt = 10'(w_y_ext - C_STEP);
      end
    end
  end

  // A corner hit flags both axes but still advances the colour only once.
  // Black (000) is skipped so the box never vanishes into the background.
  always_comb begin
    w_colour_nxt = r_colour;
    if (w_bounce_x | w_bounce_y) begin
      w_colour_nxt = (r_colour == 3'b111) ? 3'b001 : r_colour + 3'd1;
    end
  end

  assign w_inside = valid
                  & (pix_x >= r_box_x) & ({1'b0, pix_x} < w_x_ext + C_BOX_W)
                  & (pix_y >= r_box_y) & ({1'b0, pix_y} < w_y_ext + C_BOX_H);

`ifdef BOX_BORDER_EN
  assign w_border = valid & ((pix_x == 10'd0) | (pix_x == C_X_LAST)
                           | (pix_y == 10'd0) | (pix_y == C_Y_LAST));
`endif

  always_comb begin
    w_rgb_nxt = 3'b000;
    if (valid) begin
`ifdef BOX_BORDER_EN
      if (w_border) begin
        w_rgb_nxt = 3'b111;
      end else if (w_inside) begin
        w_rgb_nxt = r_colour;
      end else begin
        w_rgb_nxt = BG_RGB;
      end
`else
      w_rgb_nxt = w_inside ? r_colour : BG_RGB;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_box_x     <= 10'd0;
      r_box_y     <= 10'd0;
      r_dir_x     <= DIR_FWD;
      r_dir_y     <= DIR_FWD;
      r_colour    <= 3'b100;
      r_vys_d     <= 1'b1;  // a vys held high through reset gives no tick
      r_hys_o     <= 1'b0;
      r_vys_o     <= 1'b0;
      r_rgb       <= 3'b000;
      r_frame_cnt <= 8'd0;
    end else begin
      r_vys_d <= vys;
      r_hys_o <= hys;
      r_vys_o <= vys;
      r_rgb   <= w_rgb_nxt;
      if (w_tick) begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
        if (move_en) begin
          r_box_x  <= w_x_nxt;
          r_box_y  <= w_y_nxt;
          r_dir_x  <= w_dir_x_nxt;
          r_dir_y  <= w_dir_y_nxt;
          r_colour <= w_colour_nxt;
        end
      end
    end
  end

  assign hys_o     = r_hys_o;
  assign vys_o     = r_vys_o;
  assign rgb_r     = r_rgb[2];
  assign rgb_g     = r_rgb[1];
  assign rgb_b     = r_rgb[0];
  assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_vga_box_bounce.sv
// tb/tb_vga_box_bounce.sv - directed self-checking bench for vga_box_bounce
module tb_vga_box_bounce;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] rgb;
  } pv_t;

`ifdef BOX_BORDER_EN
  localparam logic [2:0] EDGE_RGB   = 3'b111;
  localparam logic [2:0] ORIGIN_RGB = 3'b111;
`else
  localparam logic [2:0] EDGE_RGB   = 3'b000;
  localparam logic [2:0] ORIGIN_RGB = 3'b100;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       hys;
  logic       vys;
  logic       valid;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       move_en;

  logic       hys_o, vys_o, rgb_r, rgb_g, rgb_b;
  logic [7:0] frame_cnt;
  logic       c_hys_o, c_vys_o, c_rgb_r, c_rgb_g, c_rgb_b;
  logic [7:0] c_frame_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  vga_box_bounce dut (
    .clk(clk), .reset(reset), .hys(hys), .vys(vys), .valid(valid),
    .pix_x(pix_x), .pix_y(pix_y), .move_en(move_en),
    .hys_o(hys_o), .vys_o(vys_o), .rgb_r(rgb_r), .rgb_g(rgb_g), .rgb_b(rgb_b),
    .frame_cnt(frame_cnt)
  );

  // Small arena where both axes hit their limits on the same tick (7, 14, ...).
  vga_box_bounce #(
    .H_ACT(160), .V_ACT(112), .BOX_W(64), .BOX_H(16), .STEP(16), .BG_RGB(3'b000)
  ) dut_corner (
    .clk(clk), .reset(reset), .hys(hys), .vys(vys), .valid(valid),
    .pix_x(pix_x), .pix_y(pix_y), .move_en(move_en),
    .hys_o(c_hys_o), .vys_o(c_vys_o), .rgb_r(c_rgb_r), .rgb_g(c_rgb_g), .rgb_b(c_rgb_b),
    .frame_cnt(c_frame_cnt)
  );

  task automatic probe(input logic [9:0] x, input logic [9:0] y,
                       output logic [2:0] m_rgb, output logic [2:0] c_rgb);
    @(negedge clk);
    valid = 1'b1;
    pix_x = x;
    pix_y = y;
    @(negedge clk);
    m_rgb = {rgb_r, rgb_g, rgb_b};
    c_rgb = {c_rgb_r, c_rgb_g, c_rgb_b};
    valid = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      vys = 1'b0;
      @(negedge clk);
      vys = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    valid = 1'b0;
    hys   = 1'b1;
    vys   = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if ({hys_o, vys_o, rgb_r, rgb_g, rgb_b} !== 5'b00000) begin
      miscompares++;
      $display("FAIL reset_outputs: {hys_o,vys_o,rgb}=%b expected 00000",
               {hys_o, vys_o, rgb_r, rgb_g, rgb_b});
    end
    vectors++;
    if (frame_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_frame_cnt: got %0d expected 0", frame_cnt);
    end
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if ({rgb_r, rgb_g, rgb_b} !== ORIGIN_RGB) begin
      miscompares++;
      $display("FAIL release_rgb: got %b expected %b", {rgb_r, rgb_g, rgb_b}, ORIGIN_RGB);
    end
    vectors++;
    if ({hys_o, vys_o, frame_cnt} !== {2'b11, 8'd0}) begin
      miscompares++;
      $display("FAIL release_sync: hys_o=%b vys_o=%b frame_cnt=%0d expected 1 1 0",
               hys_o, vys_o, frame_cnt);
    end
  endtask

  task automatic test_pixel();
    pv_t v[5] = '{'{10'd63, 10'd10, 3'b100}, '{10'd64, 10'd10, 3'b000},
                  '{10'd1, 10'd47, 3'b100}, '{10'd1, 10'd48, 3'b000},
                  '{10'd0, 10'd200, EDGE_RGB}};
    logic [2:0] m, c;
    foreach (v[i]) begin
      probe(v[i].x, v[i].y, m, c);
      vectors++;
      if (m !== v[i].rgb) begin
        miscompares++;
        $display("FAIL pixel_(%0d,%0d): rgb=%b expected %b", v[i].x, v[i].y, m, v[i].rgb);
      end
    end
    // Blanking is black even when the coordinates sit inside the box.
    @(negedge clk);
    valid = 1'b0;
    pix_x = 10'd10;
    pix_y = 10'd10;
    @(negedge clk);
    vectors++;
    if ({rgb_r, rgb_g, rgb_b} !== 3'b000) begin
      miscompares++;
      $display("FAIL blank_rgb: got %b expected 000", {rgb_r, rgb_g, rgb_b});
    end
  endtask

  task automatic test_border();
    logic [2:0] m, c;
    probe(10'd639, 10'd479, m, c);
    vectors++;
    if (m !== EDGE_RGB) begin
      miscompares++;
      $display("FAIL border_(639,479): rgb=%b expected %b", m, EDGE_RGB);
    end
  endtask

  task automatic test_sync();
    @(negedge clk);
    hys = 1'b0;
    @(negedge clk);
    vectors++;
    if ({hys_o, vys_o} !== 2'b01) begin
      miscompares++;
      $display("FAIL sync_hys_low: {hys_o,vys_o}=%b expected 01", {hys_o, vys_o});
    end
    hys = 1'b1;
    vys = 1'b0;
    @(negedge clk);
    vectors++;
    if ({hys_o, vys_o, frame_cnt} !== {2'b10, 8'd0}) begin
      miscompares++;
      $display("FAIL sync_vys_low: hys_o=%b vys_o=%b frame_cnt=%0d expected 1 0 0",
               hys_o, vys_o, frame_cnt);
    end
    vys = 1'b1;
    @(negedge clk);
    vectors++;
    if ({vys_o, frame_cnt} !== {1'b1, 8'd1}) begin
      miscompares++;
      $display("FAIL sync_vys_rise: vys_o=%b frame_cnt=%0d expected 1 1", vys_o, frame_cnt);
    end
  endtask

  task automatic test_freeze();
    pv_t v[4] = '{'{10'd1, 10'd1, 3'b100}, '{10'd63, 10'd47, 3'b100},
                  '{10'd64, 10'd47, 3'b000}, '{10'd63, 10'd48, 3'b000}};
    logic [2:0] m, c;
    move_en = 1'b0;
    tick(5);
    vectors++;
    if (frame_cnt !== 8'd6) begin
      miscompares++;
      $display("FAIL freeze_frame_cnt: got %0d expected 6", frame_cnt);
    end
    foreach (v[i]) begin
      probe(v[i].x, v[i].y, m, c);
      vectors++;
      if (m !== v[i].rgb) begin
        miscompares++;
        $display("FAIL freeze_(%0d,%0d): rgb=%b expected %b", v[i].x, v[i].y, m, v[i].rgb);
      end
    end
  endtask

  task automatic test_corner();
    int   n_ticks[6] = '{6, 0, 1, 7, 7, 7};
    pv_t  v[6] = '{'{10'd97, 10'd97, 3'b100}, '{10'd95, 10'd97, 3'b000},
                   '{10'd97, 10'd97, 3'b101}, '{10'd1, 10'd1, 3'b110},
                   '{10'd97, 10'd97, 3'b111}, '{10'd1, 10'd1, 3'b001}};
    logic [2:0] m, c;
    apply_reset();
    move_en = 1'b1;
    foreach (v[i]) begin
      if (n_ticks[i] > 0) tick(n_ticks[i]);
      probe(v[i].x, v[i].y, m, c);
      vectors++;
      if (c !== v[i].rgb) begin
        miscompares++;
        $display("FAIL corner_%0d_(%0d,%0d): rgb=%b expected %b", i, v[i].x, v[i].y, c, v[i].rgb);
      end
    end
  endtask

  task automatic test_bounce();
    int   n_ticks[16] = '{108, 0, 0, 1, 0, 35, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0};
    pv_t  v[16] = '{'{10'd432, 10'd432, 3'b100}, '{10'd432, 10'd431, 3'b000},
                    '{10'd431, 10'd432, 3'b000},
                    '{10'd436, 10'd432, 3'b101}, '{10'd435, 10'd432, 3'b000},
                    '{10'd576, 10'd292, 3'b101}, '{10'd575, 10'd292, 3'b000},
                    '{10'd638, 10'd339, 3'b101}, '{10'd638, 10'd340, 3'b000},
                    '{10'd576, 10'd291, 3'b000},
                    '{10'd576, 10'd288, 3'b110}, '{10'd575, 10'd288, 3'b000},
                    '{10'd572, 10'd284, 3'b110}, '{10'd571, 10'd284, 3'b000},
                    '{10'd635, 10'd284, 3'b110}, '{10'd636, 10'd284, 3'b000}};
    logic [2:0] m, c;
    apply_reset();
    move_en = 1'b1;
    foreach (v[i]) begin
      if (n_ticks[i] > 0) tick(n_ticks[i]);
      probe(v[i].x, v[i].y, m, c);
      vectors++;
      if (m !== v[i].rgb) begin
        miscompares++;
        $display("FAIL bounce_%0d_(%0d,%0d): rgb=%b expected %b", i, v[i].x, v[i].y, m, v[i].rgb);
      end
    end
    vectors++;
    if (frame_cnt !== 8'd146) begin
      miscompares++;
      $display("FAIL bounce_frame_cnt: got %0d expected 146", frame_cnt);
    end
  endtask

  task automatic test_reset_midframe();
    logic [2:0] m, c;
    @(negedge clk);
    valid = 1'b1;
    pix_x = 10'd600;
    pix_y = 10'd300;
    vys   = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if ({rgb_r, rgb_g, rgb_b, frame_cnt} !== {3'b000, 8'd0}) begin
      miscompares++;
      $display("FAIL midreset_state: rgb=%b frame_cnt=%0d expected 000 0",
               {rgb_r, rgb_g, rgb_b}, frame_cnt);
    end
    reset = 1'b0;
    valid = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (frame_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL midreset_no_tick: frame_cnt=%0d expected 0", frame_cnt);
    end
    probe(10'd1, 10'd1, m, c);
    vectors++;
    if (m !== 3'b100) begin
      miscompares++;
      $display("FAIL midreset_origin: rgb=%b expected 100", m);
    end
    probe(10'd572, 10'd284, m, c);
    vectors++;
    if (m !== 3'b000) begin
      miscompares++;
      $display("FAIL midreset_old_pos: rgb=%b expected 000", m);
    end
    tick(1);
    vectors++;
    if (frame_cnt !== 8'd1) begin
      miscompares++;
      $display("FAIL midreset_first_tick: frame_cnt=%0d expected 1", frame_cnt);
    end
  endtask

  task automatic test_frame_wrap();
    move_en = 1'b0;
    tick(254);
    vectors++;
    if (frame_cnt !== 8'd255) begin
      miscompares++;
      $display("FAIL wrap_255: frame_cnt=%0d expected 255", frame_cnt);
    end
    tick(1);
    vectors++;
    if (frame_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL wrap_0: frame_cnt=%0d expected 0", frame_cnt);
    end
  endtask

  initial begin
    reset   = 1'b1;
    hys     = 1'b1;
    vys     = 1'b1;
    valid   = 1'b1;
    pix_x   = 10'd0;
    pix_y   = 10'd0;
    move_en = 1'b0;
    test_reset();
    test_pixel();
    test_border();
    test_sync();
    test_freeze();
    test_corner();
    test_bounce();
    test_reset_midframe();
    test_frame_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
